// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register slice.
//   MODE_*  : two-bit operation codes presented on the 'mode' port
//   state_t : burst controller states (idle / auto-shifting)
// -----------------------------------------------------------------------------
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// usr_burst_ctrl
// Sequencer for the universal shift register. Decides, every cycle, whether
// the datapath loads, shifts (and in which direction) or holds, and runs the
// multi-cycle shift burst with its busy/done handshake.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   mode        : requested operation (usr_pkg MODE_* codes)
//   start, cnt  : burst request and burst length (sampled together)
//   shift_en    : datapath shifts this cycle
//   shift_left  : direction of that shift (1 = toward MSB)
//   load_en     : datapath loads parallel data this cycle
//   busy, done  : registered burst status / one-cycle completion pulse
// -----------------------------------------------------------------------------
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
   output logic             shift_en,
   output logic             shift_left,
   output logic             load_en,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             dir_left;
   logic             mode_is_shift;

   assign mode_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

   // Per-cycle datapath command. A start request with a shift mode only
   // arms the burst, so the register does not move in that cycle; start with
   // HOLD/LOAD is ignored and the plain single op happens instead.
   always_comb begin
      shift_en   = 1'b0;
      shift_left = 1'b0;
      load_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            load_en    = (mode == MODE_LOAD);
            shift_en   = mode_is_shift && !start;
            shift_left = (mode == MODE_SHL);
         end
         ST_SHIFT: begin
            shift_en   = 1'b1;
            shift_left = dir_left;
         end
         default: begin
            shift_en = 1'b0;
         end
      endcase
   end

   // Burst FSM with down-counter. busy mirrors the SHIFT state, done is a
   // single-cycle pulse raised either at the end of a burst or immediately
   // for a zero-length request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         dir_left <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && mode_is_shift) begin
                  dir_left <= (mode == MODE_SHL);
                  if (cnt != '0) begin
                     count <= cnt;
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               count <= count - 1'b1;
               if (count == CNT_W'(1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register: hold, shift right, shift left,
// parallel load, serial in/out and an auto-sequenced shift burst.
// Optional feature macro: USR_ROTATE_EN adds the 'rot' input; with rot=1 the
// bit shifted out re-enters at the other end instead of the serial input.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mode                     : 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   b                        : parallel load data
//   ser_msb_in, ser_lsb_in   : serial fill bits for SHR / SHL
//   rot                      : rotate select (only with USR_ROTATE_EN)
//   start, cnt               : burst request and length
//   a                        : register contents
//   ser_lsb_out, ser_msb_out : a[0] / a[WIDTH-1]
//   busy, done               : burst status / completion pulse
// -----------------------------------------------------------------------------
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] b,
   input  logic             ser_msb_in,
   input  logic             ser_lsb_in,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
   output logic [WIDTH-1:0] a,
   output logic             ser_lsb_out,
   output logic             ser_msb_out,
   output logic             busy,
   output logic             done
);

   logic shift_en;
   logic shift_left;
   logic load_en;
   logic rot_sel;
   logic msb_fill;
   logic lsb_fill;

`ifdef USR_ROTATE_EN
   assign rot_sel = rot;
`else
   assign rot_sel = 1'b0;
`endif

   // Rotation feeds the departing bit back in at the opposite end.
   assign msb_fill = rot_sel ? a[0]       : ser_msb_in;
   assign lsb_fill = rot_sel ? a[WIDTH-1] : ser_lsb_in;

   assign ser_lsb_out = a[0];
   assign ser_msb_out = a[WIDTH-1];

   usr_burst_ctrl #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .start      (start),
      .cnt        (cnt),
      .shift_en   (shift_en),
      .shift_left (shift_left),
      .load_en    (load_en),
      .busy       (busy),
      .done       (done)
   );

   // Data register, driven by the per-cycle command from the controller.
   always_ff @(posedge clk) begin
      if (rst) begin
         a <= '0;
      end else if (load_en) begin
         a <= b;
      end else if (shift_en) begin
         if (shift_left) begin
            a <= {a[WIDTH-2:0], lsb_fill};
         end else begin
            a <= {msb_fill, a[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4): directed
// scenarios followed by random traffic, compared against a behavioural model.
// Honours USR_ROTATE_EN when defined.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] SHR  = 2'b01;
   localparam logic [1:0] SHL  = 2'b10;
   localparam logic [1:0] LOAD = 2'b11;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       mode;
   logic [WIDTH-1:0] b;
   logic             ser_msb_in;
   logic             ser_lsb_in;
   logic             rot;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a;
   logic             ser_lsb_out;
   logic             ser_msb_out;
   logic             busy;
   logic             done;

   int total = 0;
   int bad   = 0;

   // Reference model: register value, shifts left in the current burst,
   // burst direction and the done flag.
   int               m_a;
   int               m_left;
   bit               m_dir_left;
   bit               m_done;

   univ_shift_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .b           (b),
      .ser_msb_in  (ser_msb_in),
      .ser_lsb_in  (ser_lsb_in),
`ifdef USR_ROTATE_EN
      .rot         (rot),
`endif
      .start       (start),
      .cnt         (cnt),
      .a           (a),
      .ser_lsb_out (ser_lsb_out),
      .ser_msb_out (ser_msb_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One shift computed arithmetically: right divides by two and adds the
   // fill at the top, left doubles and adds the fill at the bottom.
   function automatic int shiftValue(input int value, input bit left, input bit fill_in, input bit rt);
      int  mask;
      bit  fill;
      mask = (1 << WIDTH) - 1;
      if (left) begin
         fill = rt ? bit'((value >> (WIDTH - 1)) & 1) : fill_in;
         return ((value * 2) + int'(fill)) & mask;
      end else begin
         fill = rt ? bit'(value & 1) : fill_in;
         return (value / 2) + (int'(fill) << (WIDTH - 1));
      end
   endfunction

   // Drive one cycle of inputs, clock it, advance the model and compare.
   task automatic applyStimulus(input bit r, input logic [1:0] md, input logic [WIDTH-1:0] bb,
                                input bit msi, input bit lsi, input bit st,
                                input logic [CNT_W-1:0] c, input bit rt);
      bit rt_eff;
`ifdef USR_ROTATE_EN
      rt_eff = rt;
`else
      rt_eff = 1'b0;
`endif
      rst = r; mode = md; b = bb; ser_msb_in = msi; ser_lsb_in = lsi;
      start = st; cnt = c; rot = rt;
      @(posedge clk);
      if (r) begin
         m_a = 0; m_left = 0; m_done = 1'b0;
      end else if (m_left > 0) begin
         m_a    = shiftValue(m_a, m_dir_left, m_dir_left ? lsi : msi, rt_eff);
         m_left = m_left - 1;
         m_done = (m_left == 0);
      end else begin
         m_done = 1'b0;
         if (st && (md == SHR || md == SHL)) begin
            m_dir_left = (md == SHL);
            if (c == 0) m_done = 1'b1;
            else        m_left = int'(c);
         end else if (md == LOAD) begin
            m_a = int'(bb);
         end else if (md == SHR) begin
            m_a = shiftValue(m_a, 1'b0, msi, rt_eff);
         end else if (md == SHL) begin
            m_a = shiftValue(m_a, 1'b1, lsi, rt_eff);
         end
      end
      #1;
      checkOutput("a",       32'(a),           32'(m_a));
      checkOutput("busy",    32'(busy),        32'(m_left > 0));
      checkOutput("done",    32'(done),        32'(m_done));
      checkOutput("lsb_out", 32'(ser_lsb_out), 32'(m_a & 1));
      checkOutput("msb_out", 32'(ser_msb_out), 32'((m_a >> (WIDTH - 1)) & 1));
   endtask

   initial begin
      m_a = 0; m_left = 0; m_dir_left = 1'b0; m_done = 1'b0;
      rst = 1'b1; mode = HOLD; b = '0; ser_msb_in = 1'b0; ser_lsb_in = 1'b0;
      rot = 1'b0; start = 1'b0; cnt = '0;

      // Reset wins over a pending load; then a plain load.
      applyStimulus(1, LOAD, 8'hFF, 0, 0, 0, 0, 0);
      checkOutput("reset_a", 32'(a), 32'h00);
      applyStimulus(0, LOAD, 8'hA5, 0, 0, 0, 0, 0);
      checkOutput("load_a5", 32'(a), 32'hA5);

      // Two single right shifts with a 1 entering the MSB.
      applyStimulus(0, SHR, 8'h00, 1, 0, 0, 0, 0);
      checkOutput("shr1", 32'(a), 32'hD2);
      checkOutput("shr1_lsb", 32'(ser_lsb_out), 32'h0);
      applyStimulus(0, SHR, 8'h00, 1, 0, 0, 0, 0);
      checkOutput("shr2", 32'(a), 32'hE9);
      checkOutput("shr2_lsb", 32'(ser_lsb_out), 32'h1);

      // Three-shift left burst; mode and b wiggle underneath it.
      applyStimulus(0, LOAD, 8'h81, 0, 0, 0, 0, 0);
      applyStimulus(0, SHL, 8'h00, 0, 0, 1, 3, 0);
      checkOutput("burst_busy0", 32'(busy), 32'h1);
      checkOutput("burst_a0", 32'(a), 32'h81);
      applyStimulus(0, LOAD, 8'h5A, 1, 0, 1, 7, 0);
      applyStimulus(0, SHR, 8'hC3, 1, 0, 0, 2, 0);
      applyStimulus(0, LOAD, 8'h11, 0, 0, 1, 1, 0);
      checkOutput("burst_a", 32'(a), 32'h08);
      checkOutput("burst_done", 32'(done), 32'h1);
      checkOutput("burst_busy", 32'(busy), 32'h0);
      applyStimulus(0, HOLD, 8'h00, 0, 0, 0, 0, 0);
      checkOutput("done_pulse", 32'(done), 32'h0);

      // Zero-length burst, then start with LOAD acts as a load.
      applyStimulus(0, SHR, 8'h00, 1, 1, 1, 0, 0);
      checkOutput("cnt0_a", 32'(a), 32'h08);
      checkOutput("cnt0_done", 32'(done), 32'h1);
      applyStimulus(0, LOAD, 8'h3C, 0, 0, 1, 5, 0);
      checkOutput("start_load_a", 32'(a), 32'h3C);
      checkOutput("start_load_done", 32'(done), 32'h0);

      // Long burst aborted by reset after four shifts.
      applyStimulus(0, LOAD, 8'hFF, 0, 0, 0, 0, 0);
      applyStimulus(0, SHR, 8'h00, 0, 0, 1, 10, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, HOLD, 8'h00, 0, 0, 0, 0, 0);
      checkOutput("abort_pre", 32'(a), 32'h0F);
      applyStimulus(1, HOLD, 8'h00, 0, 0, 0, 0, 0);
      checkOutput("abort_a", 32'(a), 32'h00);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      applyStimulus(0, HOLD, 8'h00, 0, 0, 0, 0, 0);
      checkOutput("abort_done", 32'(done), 32'h0);

`ifdef USR_ROTATE_EN
      // Rotation: burst of one left and a single right op.
      applyStimulus(0, LOAD, 8'h81, 0, 0, 0, 0, 0);
      applyStimulus(0, SHL, 8'h00, 0, 0, 1, 1, 1);
      applyStimulus(0, HOLD, 8'h00, 0, 0, 0, 0, 1);
      checkOutput("rot_shl", 32'(a), 32'h03);
      applyStimulus(0, LOAD, 8'h01, 0, 0, 0, 0, 0);
      applyStimulus(0, SHR, 8'h00, 0, 0, 0, 0, 1);
      checkOutput("rot_shr", 32'(a), 32'h80);
`endif

      // Random traffic, occasional reset, frequent burst requests.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       2'($urandom_range(0, 3)),
                       WIDTH'($urandom),
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0),
                       CNT_W'($urandom),
                       1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
